// File: rtl/serv_sram8_bridge.sv
// Arbitrates the SERV ibus/dbus onto one 8-bit asynchronous SRAM, one byte slot per enabled byte.
// Every output is a flop loaded from the next-state values, so the SRAM pins are glitch-free.
module serv_sram8_bridge #(
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_ibus_adr,
    input  logic                  i_ibus_cyc,
    output logic [31:0]           o_ibus_rdt,
    output logic                  o_ibus_ack,
    input  logic [31:0]           i_dbus_adr,
    input  logic [31:0]           i_dbus_dat,
    input  logic [3:0]            i_dbus_sel,
    input  logic                  i_dbus_we,
    input  logic                  i_dbus_cyc,
    output logic [31:0]           o_dbus_rdt,
    output logic                  o_dbus_ack,
    output logic [ADDR_WIDTH-1:0] o_sram_adr,
    output logic [7:0]            o_sram_dat,
    output logic                  o_sram_dat_oe,
    input  logic [7:0]            i_sram_dat,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);

    localparam int CW = $clog2(WAIT_STATES + 2);
    localparam logic [CW-1:0] LAST = CW'(WAIT_STATES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

    state_t                r_state, w_state;
    logic [1:0]            r_byte, w_byte;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  r_gnt_d, w_gnt_d;
    logic                  r_we, w_we;
    logic [3:0]            r_sel, w_sel;
    logic [31:0]           r_dat, w_dat;
    logic [ADDR_WIDTH-3:0] r_wadr, w_wadr;
    logic [31:0]           r_rdt, w_rdt;
    logic [2:0]            w_nb;
    logic                  w_unused;

    assign w_unused = ^{i_ibus_adr[31:ADDR_WIDTH], i_ibus_adr[1:0],
                        i_dbus_adr[31:ADDR_WIDTH], i_dbus_adr[1:0]};

    // {found, index} of the lowest enabled byte at or above 'from'
    function automatic logic [2:0] first_en(input logic [3:0] sel, input int from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (k >= from && sel[k]) r = {1'b1, 2'(k)};
        end
        return r;
    endfunction

    always_comb begin
        w_state = r_state;
        w_byte  = r_byte;
        w_cnt   = r_cnt;
        w_gnt_d = r_gnt_d;
        w_we    = r_we;
        w_sel   = r_sel;
        w_dat   = r_dat;
        w_wadr  = r_wadr;
        w_rdt   = r_rdt;
        w_nb    = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (i_dbus_cyc || i_ibus_cyc) begin
                    w_gnt_d = i_dbus_cyc;
                    w_cnt   = '0;
                    if (i_dbus_cyc) begin
                        w_we   = i_dbus_we;
                        w_sel  = i_dbus_we ? i_dbus_sel : 4'hF;
                        w_dat  = i_dbus_dat;
                        w_wadr = i_dbus_adr[ADDR_WIDTH-1:2];
                    end else begin
                        w_we   = 1'b0;
                        w_sel  = 4'hF;
                        w_dat  = r_dat;
                        w_wadr = i_ibus_adr[ADDR_WIDTH-1:2];
                    end
                    // reads latch sel=1111 so they share the byte-skip walk
                    w_nb = first_en(w_sel, 0);
                    if (w_nb[2]) begin
                        w_state = S_ACCESS;
                        w_byte  = w_nb[1:0];
                    end else begin
                        w_state = S_ACK;
                        w_byte  = 2'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt == LAST) begin
                    w_cnt = '0;
                    if (!r_we) w_rdt[8*r_byte +: 8] = i_sram_dat;
                    w_nb = first_en(r_sel, int'(r_byte) + 1);
                    if (w_nb[2]) w_byte = w_nb[1:0];
                    else         w_state = S_ACK;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_ACK:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_byte        <= 2'd0;
            r_cnt         <= '0;
            r_gnt_d       <= 1'b0;
            r_we          <= 1'b0;
            r_sel         <= 4'h0;
            r_dat         <= 32'h0;
            r_wadr        <= '0;
            r_rdt         <= 32'h0;
            o_ibus_rdt    <= 32'h0;
            o_ibus_ack    <= 1'b0;
            o_dbus_rdt    <= 32'h0;
            o_dbus_ack    <= 1'b0;
            o_sram_adr    <= '0;
            o_sram_dat    <= 8'h0;
            o_sram_dat_oe <= 1'b0;
            o_sram_ce_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
        end else begin
            r_state       <= w_state;
            r_byte        <= w_byte;
            r_cnt         <= w_cnt;
            r_gnt_d       <= w_gnt_d;
            r_we          <= w_we;
            r_sel         <= w_sel;
            r_dat         <= w_dat;
            r_wadr        <= w_wadr;
            r_rdt         <= w_rdt;
            o_sram_adr    <= {w_wadr, w_byte};
            o_sram_dat    <= w_dat[8*w_byte +: 8];
            o_sram_dat_oe <= (w_state == S_ACCESS) && w_we;
            o_sram_ce_n   <= (w_state != S_ACCESS);
            o_sram_oe_n   <= !((w_state == S_ACCESS) && !w_we && (w_cnt != '0));
            o_sram_we_n   <= !((w_state == S_ACCESS) && w_we && (w_cnt != '0));
            o_ibus_ack    <= (w_state == S_ACK) && !w_gnt_d;
            o_dbus_ack    <= (w_state == S_ACK) && w_gnt_d;
            // the word is published on the edge entering ACK so rdt is valid with ack
            if (w_state == S_ACK && r_state != S_ACK && !w_we) begin
                if (w_gnt_d) o_dbus_rdt <= w_rdt;
                else         o_ibus_rdt <= w_rdt;
            end
        end
    end

endmodule

// File: tb/tb_serv_sram8_bridge.sv
// Scoreboard bench: three bridges (WAIT_STATES 1, 0, 3) run the same directed and random traffic
// against a byte-array SRAM model; expectations come from a flat reference memory.
module tb_serv_sram8_bridge;
    localparam int AW = 19;
    localparam logic [31:0] AMASK = 32'h0007_FFFC;

    typedef struct {
        logic [31:0] data;
        bit          chkd;
        int          ack_at;
        int          oe_exp;
        int          we_exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int WS   = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int RLAT = 4 * (WS + 2) + 1;

        logic          rst, ibus_cyc, ibus_ack, dbus_cyc, dbus_we, dbus_ack;
        logic [31:0]   ibus_adr, ibus_rdt, dbus_adr, dbus_dat, dbus_rdt;
        logic [3:0]    dbus_sel;
        logic [AW-1:0] sram_adr;
        logic [7:0]    sram_dat, sram_q;
        logic          sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n;

        logic [7:0] mem[int];
        logic [7:0] refm[int];
        exp_t iq[$];
        exp_t dq[$];
        int   cyc_cnt = 0;
        int   oe_cnt = 0;
        int   we_cnt = 0;
        logic prev_we_n = 1'b1;

        serv_sram8_bridge #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
            .clk(clk), .i_rst(rst),
            .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
            .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
            .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
            .o_sram_adr(sram_adr), .o_sram_dat(sram_dat), .o_sram_dat_oe(sram_dat_oe),
            .i_sram_dat(sram_q), .o_sram_ce_n(sram_ce_n), .o_sram_oe_n(sram_oe_n),
            .o_sram_we_n(sram_we_n)
        );

        always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

        function automatic logic [7:0] mem_rd(input int a);
            return mem.exists(a) ? mem[a] : init_byte(a);
        endfunction

        function automatic logic [7:0] ref_rd(input int a);
            return refm.exists(a) ? refm[a] : init_byte(a);
        endfunction

        function automatic logic [31:0] ref_word(input logic [31:0] adr);
            int b;
            b = int'(adr & AMASK);
            return {ref_rd(b + 3), ref_rd(b + 2), ref_rd(b + 1), ref_rd(b)};
        endfunction

        // SRAM: read data settles mid-cycle, writes land while ce/we are low and the bus is driven
        always @(negedge clk) begin
            if (!sram_ce_n && !sram_we_n && sram_dat_oe) mem[int'(sram_adr)] = sram_dat;
            sram_q = (!sram_ce_n && !sram_oe_n) ? mem_rd(int'(sram_adr)) : 8'h00;
        end

        task automatic check_ack(input exp_t e, input logic [31:0] rdt, input string m);
            if (e.chkd) chk($sformatf("W%0d %s rdt", WS, m), rdt, e.data);
            if (e.ack_at >= 0) chk($sformatf("W%0d %s ack cycle", WS, m), cyc_cnt, e.ack_at);
            chk($sformatf("W%0d %s oe_n low cycles", WS, m), oe_cnt, e.oe_exp);
            chk($sformatf("W%0d %s we_n pulses", WS, m), we_cnt, e.we_exp);
            oe_cnt = 0;
            we_cnt = 0;
        endtask

        always @(negedge clk) begin
            if (rst) begin
                oe_cnt = 0;
                we_cnt = 0;
            end else begin
                if (!sram_oe_n) oe_cnt++;
                if (!sram_we_n && prev_we_n) we_cnt++;
                if (ibus_ack || dbus_ack)
                    chk($sformatf("W%0d dual ack", WS), {31'b0, ibus_ack & dbus_ack}, 32'd0);
                if (ibus_ack) begin
                    if (iq.size() == 0) chk($sformatf("W%0d ibus spurious ack", WS), iq.size(), 1);
                    else check_ack(iq.pop_front(), ibus_rdt, "ibus");
                end
                if (dbus_ack) begin
                    if (dq.size() == 0) chk($sformatf("W%0d dbus spurious ack", WS), dq.size(), 1);
                    else check_ack(dq.pop_front(), dbus_rdt, "dbus");
                end
            end
            prev_we_n = sram_we_n;
        end

        task automatic preset(input int a, input logic [7:0] b);
            mem[a]  = b;
            refm[a] = b;
        endtask

        // delay < 0: no timing check (request may queue behind the other master)
        task automatic do_i(input logic [31:0] adr, input int delay);
            exp_t e;
            int t;
            @(negedge clk);
            ibus_adr = adr;
            ibus_cyc = 1'b1;
            e.data = ref_word(adr);
            e.chkd = 1'b1;
            e.ack_at = (delay < 0) ? -1 : cyc_cnt + delay;
            e.oe_exp = 4 * (WS + 1);
            e.we_exp = 0;
            iq.push_back(e);
            t = 0;
            do begin @(negedge clk); t++; end while (!ibus_ack && t < 400);
            if (!ibus_ack) chk($sformatf("W%0d ibus ack timeout", WS), {31'b0, ibus_ack}, 32'd1);
            ibus_cyc = 1'b0;
        endtask

        task automatic do_d(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int delay);
            exp_t e;
            int t, b;
            @(negedge clk);
            dbus_we  = we;
            dbus_adr = adr;
            dbus_dat = dat;
            dbus_sel = sel;
            dbus_cyc = 1'b1;
            b = int'(adr & AMASK);
            if (we) for (int k = 0; k < 4; k++) if (sel[k]) refm[b + k] = dat[8*k +: 8];
            e.data = ref_word(adr);
            e.chkd = !we;
            e.ack_at = (delay < 0) ? -1 : cyc_cnt + delay;
            e.oe_exp = we ? 0 : 4 * (WS + 1);
            e.we_exp = we ? $countones(sel) : 0;
            dq.push_back(e);
            t = 0;
            do begin @(negedge clk); t++; end while (!dbus_ack && t < 400);
            if (!dbus_ack) chk($sformatf("W%0d dbus ack timeout", WS), {31'b0, dbus_ack}, 32'd1);
            dbus_cyc = 1'b0;
        endtask

        initial begin : drv
            rst = 1'b1; ibus_cyc = 1'b0; ibus_adr = '0;
            dbus_cyc = 1'b0; dbus_we = 1'b0; dbus_adr = '0; dbus_dat = '0; dbus_sel = '0;
            repeat (3) @(negedge clk);
            chk($sformatf("W%0d reset acks", WS), {30'b0, ibus_ack, dbus_ack}, 32'd0);
            chk($sformatf("W%0d reset ibus_rdt", WS), ibus_rdt, 32'd0);
            chk($sformatf("W%0d reset dbus_rdt", WS), dbus_rdt, 32'd0);
            chk($sformatf("W%0d reset strobes", WS),
                {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dat_oe}, 32'hE);
            chk($sformatf("W%0d reset sram_adr", WS), 32'(sram_adr), 32'd0);
            rst = 1'b0;

            preset(32'h100, 8'h11); preset(32'h101, 8'h22);
            preset(32'h102, 8'h33); preset(32'h103, 8'h44);
            do_i(32'h100, RLAT);

            do_d(1'b1, 32'h200, 32'hDEADBEEF, 4'hF, RLAT);
            chk($sformatf("W%0d mem 200", WS), 32'(mem_rd(32'h200)), 32'hEF);
            chk($sformatf("W%0d mem 201", WS), 32'(mem_rd(32'h201)), 32'hBE);
            chk($sformatf("W%0d mem 202", WS), 32'(mem_rd(32'h202)), 32'hAD);
            chk($sformatf("W%0d mem 203", WS), 32'(mem_rd(32'h203)), 32'hDE);
            do_d(1'b0, 32'h200, 32'h0, 4'hF, RLAT);

            do_d(1'b1, 32'h300, 32'hAABBCCDD, 4'b0101, 2 * (WS + 2) + 1);
            chk($sformatf("W%0d mem 300", WS), 32'(mem_rd(32'h300)), 32'hDD);
            chk($sformatf("W%0d mem 301", WS), 32'(mem_rd(32'h301)), 32'(init_byte(32'h301)));
            chk($sformatf("W%0d mem 302", WS), 32'(mem_rd(32'h302)), 32'hBB);
            chk($sformatf("W%0d mem 303", WS), 32'(mem_rd(32'h303)), 32'(init_byte(32'h303)));
            do_d(1'b1, 32'h304, 32'h12345678, 4'b0000, 1);
            chk($sformatf("W%0d mem 304", WS), 32'(mem_rd(32'h304)), 32'(init_byte(32'h304)));

            // simultaneous requests: dbus first, ibus one idle cycle after dbus ack
            fork
                do_d(1'b0, 32'h300, 32'h0, 4'hF, RLAT);
                do_i(32'h100, 2 * RLAT + 1);
            join

            // reset during the byte-2 strobe of a read
            @(negedge clk);
            ibus_adr = 32'h200;
            ibus_cyc = 1'b1;
            repeat (2 * (WS + 2) + 2) @(negedge clk);
            rst = 1'b1;
            ibus_cyc = 1'b0;
            @(negedge clk);
            chk($sformatf("W%0d abort ce_n", WS), {31'b0, sram_ce_n}, 32'd1);
            chk($sformatf("W%0d abort oe_n", WS), {31'b0, sram_oe_n}, 32'd1);
            rst = 1'b0;
            repeat (RLAT + 5) @(negedge clk);
            do_i(32'h200, RLAT);

            fork
                begin
                    logic [31:0] a;
                    for (int i = 0; i < 30; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        a = ($urandom() & 32'hFFF8_0000) | (32'h1000 + 32'(4 * $urandom_range(0, 63)))
                            | 32'($urandom_range(0, 3));
                        do_i(a, -1);
                    end
                end
                begin
                    logic [31:0] a;
                    for (int i = 0; i < 30; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        a = ($urandom() & 32'hFFF8_0000) | (32'h2000 + 32'(4 * $urandom_range(0, 15)));
                        do_d(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), -1);
                    end
                end
            join
            done_cnt++;
        end
    end

    initial begin : main
        int t;
        t = 0;
        while (done_cnt < 3 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < 3) chk("run timeout", done_cnt, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
